// File: rtl/spi_master_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the shared spi_master.
// The slave modport is the arbiter's view; master is the environment driving it.
interface spi_master_arbiter_if #(
  parameter int N_REQ           = 4,
  parameter int MOSI_DATA_WIDTH = 8,
  parameter int MISO_DATA_WIDTH = 8
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_rd;
  logic [N_REQ*MOSI_DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0]                 rsp_valid;
  logic [MISO_DATA_WIDTH-1:0]       rsp_data;
  logic                             rsp_err;
  logic                             arb_busy;
  logic                             spi_wr_cmd;
  logic                             spi_rd_cmd;
  logic [MOSI_DATA_WIDTH-1:0]       mosi_data;
  logic                             spi_busy;
  logic [MISO_DATA_WIDTH-1:0]       miso_data;
  logic                             ncs_pin;
  logic [N_REQ-1:0]                 ncs_out;

  modport slave (
    input  req_valid, req_rd, req_data, spi_busy, miso_data, ncs_pin,
    output req_ready, rsp_valid, rsp_data, rsp_err, arb_busy,
           spi_wr_cmd, spi_rd_cmd, mosi_data, ncs_out
  );

  modport master (
    output req_valid, req_rd, req_data, spi_busy, miso_data, ncs_pin,
    input  req_ready, rsp_valid, rsp_data, rsp_err, arb_busy,
           spi_wr_cmd, spi_rd_cmd, mosi_data, ncs_out
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master between N_REQ requesters: one word
// transaction at a time, per-requester response and chip-select demux.
module spi_master_arbiter #(
  parameter int N_REQ           = 4,
  parameter int MOSI_DATA_WIDTH = 8,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int START_TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]           idx_q, idx_d;
  logic                       rd_q, rd_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [N_REQ-1:0]           req_ready_q, req_ready_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [MISO_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       arb_busy_q, arb_busy_d;
  logic                       wr_cmd_q, wr_cmd_d;
  logic                       rd_cmd_q, rd_cmd_d;
  logic [MOSI_DATA_WIDTH-1:0] mosi_q, mosi_d;

  logic                       any_req;
  logic [PTR_W-1:0]           pick;
  logic [PTR_W-1:0]           cand;
  logic [CNT_W-1:0]           cnt_inc;
  logic                       timeout;
  logic [MOSI_DATA_WIDTH-1:0] req_word [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign req_word[g] = bus.req_data[g*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(START_TIMEOUT));

  // First pending requester at or after rr_ptr, wrapping around
  always_comb begin
    int j;
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = PTR_W'(j);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_req && !bus.spi_busy) state_d = GRANT;
      GRANT:     state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.spi_busy)  state_d = WAIT_DONE;
        else if (timeout)  state_d = RESP;
      end
      WAIT_DONE: if (!bus.spi_busy) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from state_d so each pulse lines up with its state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    mosi_d     = mosi_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (state_d == GRANT) begin
        idx_d  = pick;
        rd_d   = bus.req_rd[pick];
        mosi_d = req_word[pick];
      end
      GRANT:     rr_ptr_d = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
      ISSUE:     cnt_d = '0;
      WAIT_BUSY: if (!bus.spi_busy) begin
        cnt_d = cnt_inc;
        if (timeout) err_d = 1'b1;
      end
      WAIT_DONE: if (!bus.spi_busy) rsp_data_d = bus.miso_data;
      RESP:      err_d = 1'b0;
      default:   ;
    endcase

    req_ready_d = '0;
    rsp_valid_d = '0;
    wr_cmd_d    = 1'b0;
    rd_cmd_d    = 1'b0;
    rsp_err_d   = 1'b0;
    if (state_d == GRANT) req_ready_d[idx_d] = 1'b1;
    if (state_d == ISSUE) begin
      wr_cmd_d = !rd_q;
      rd_cmd_d = rd_q;
    end
    if (state_d == RESP) begin
      rsp_valid_d[idx_q] = 1'b1;
      rsp_err_d          = err_d;
    end
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      rd_q        <= 1'b0;
      mosi_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      wr_cmd_q    <= 1'b0;
      rd_cmd_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      arb_busy_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      mosi_q      <= mosi_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_cmd_q    <= wr_cmd_d;
      rd_cmd_q    <= rd_cmd_d;
      rsp_err_q   <= rsp_err_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

  // Only the owner of an issued transaction sees the master's chip-select
  always_comb begin
    bus.ncs_out = '1;
    if (state_q inside {ISSUE, WAIT_BUSY, WAIT_DONE, RESP}) bus.ncs_out[idx_q] = bus.ncs_pin;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.arb_busy   = arb_busy_q;
  assign bus.spi_wr_cmd = wr_cmd_q;
  assign bus.spi_rd_cmd = rd_cmd_q;
  assign bus.mosi_data  = mosi_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a simple spi_master stand-in that
// raises busy two cycles after a command and holds it for modelLen cycles.
module tb_spi_master_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.N_REQ(4), .MOSI_DATA_WIDTH(8), .MISO_DATA_WIDTH(8)) bus ();

  spi_master_arbiter #(
    .N_REQ(4), .MOSI_DATA_WIDTH(8), .MISO_DATA_WIDTH(8), .START_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad = 0;
  int   modelLen = 16;
  logic modelDead = 1'b0;
  int   delayCnt;
  int   busyCnt;

  // modelDead makes the master ignore commands so start timeouts can be provoked
  always @(posedge clk) begin
    if (rst) begin
      bus.spi_busy <= 1'b0;
      bus.ncs_pin  <= 1'b1;
      delayCnt     <= 0;
      busyCnt      <= 0;
    end else if ((bus.spi_wr_cmd || bus.spi_rd_cmd) && !modelDead) begin
      delayCnt <= 2;
    end else if (delayCnt != 0) begin
      delayCnt <= delayCnt - 1;
      if (delayCnt == 1) begin
        bus.spi_busy <= 1'b1;
        bus.ncs_pin  <= 1'b0;
        busyCnt      <= modelLen;
      end
    end else if (busyCnt != 0) begin
      busyCnt <= busyCnt - 1;
      if (busyCnt == 1) begin
        bus.spi_busy <= 1'b0;
        bus.ncs_pin  <= 1'b1;
      end
    end
  end

  task automatic waitReady(output int cyc, output logic [3:0] rdy);
    cyc = 0;
    rdy = '0;
    while (cyc < 200 && rdy == 4'b0000) begin
      @(negedge clk);
      cyc++;
      rdy = bus.req_ready;
    end
  endtask

  // badNcs counts cycles where ncs_out differs from the owner-only copy of ncs_pin
  task automatic waitResp(input int owner, output int cyc, output logic [3:0] rv,
                          output logic [7:0] rdat, output logic re, output int badNcs);
    logic [3:0] expNcs;
    cyc = 0;
    badNcs = 0;
    rv = '0;
    rdat = '0;
    re = 1'b0;
    while (cyc < 400 && rv == 4'b0000) begin
      @(negedge clk);
      cyc++;
      expNcs = bus.ncs_pin ? 4'hF : ~(4'b0001 << owner);
      if (bus.ncs_out !== expNcs) badNcs++;
      rv   = bus.rsp_valid;
      rdat = bus.rsp_data;
      re   = bus.rsp_err;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_rd = '0;
    bus.req_data = '0;
    bus.miso_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid} !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_ready_valid got=%h exp=00", {bus.req_ready, bus.rsp_valid});
    end
    total++;
    if ({bus.spi_wr_cmd, bus.spi_rd_cmd, bus.rsp_err, bus.arb_busy} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=0000",
                      {bus.spi_wr_cmd, bus.spi_rd_cmd, bus.rsp_err, bus.arb_busy});
    end
    total++;
    if ({bus.mosi_data, bus.rsp_data} !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_data got=%h exp=0000", {bus.mosi_data, bus.rsp_data});
    end
    total++;
    if (bus.ncs_out !== 4'hF) begin
      bad++; $display("[TB] FAIL reset_ncs got=%b exp=1111", bus.ncs_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    int cyc, badNcs;
    logic [3:0] rv;
    logic [7:0] rdat;
    logic re;
    modelLen = 16;
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_rd = 4'b0000;
    bus.req_data = 32'h0000_00A3;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("[TB] FAIL wr_ready got=%b exp=0001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if ({bus.spi_wr_cmd, bus.spi_rd_cmd} !== 2'b10) begin
      bad++; $display("[TB] FAIL wr_cmd got=%b exp=10", {bus.spi_wr_cmd, bus.spi_rd_cmd});
    end
    total++;
    if (bus.mosi_data !== 8'hA3) begin
      bad++; $display("[TB] FAIL wr_mosi got=%h exp=a3", bus.mosi_data);
    end
    @(negedge clk);
    total++;
    if ({bus.spi_wr_cmd, bus.spi_rd_cmd} !== 2'b00) begin
      bad++; $display("[TB] FAIL wr_cmd_pulse got=%b exp=00", {bus.spi_wr_cmd, bus.spi_rd_cmd});
    end
    waitResp(0, cyc, rv, rdat, re, badNcs);
    total++;
    if (rv !== 4'b0001 || re !== 1'b0) begin
      bad++; $display("[TB] FAIL wr_rsp got=%b/%b exp=0001/0", rv, re);
    end
    total++;
    if (badNcs !== 0) begin
      bad++; $display("[TB] FAIL wr_ncs got=%0d exp=0 bad cycles", badNcs);
    end
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.arb_busy} !== 5'b00000) begin
      bad++; $display("[TB] FAIL wr_after got=%b exp=00000", {bus.rsp_valid, bus.arb_busy});
    end
  endtask

  task automatic test_read;
    int cyc, badNcs;
    logic [3:0] rdy, rv;
    logic [7:0] rdat;
    logic re;
    bus.miso_data = 8'hC5;
    bus.req_valid = 4'b0100;
    bus.req_rd = 4'b0100;
    bus.req_data = 32'h005A_0000;
    waitReady(cyc, rdy);
    total++;
    if (rdy !== 4'b0100) begin
      bad++; $display("[TB] FAIL rd_ready got=%b exp=0100", rdy);
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if ({bus.spi_wr_cmd, bus.spi_rd_cmd, bus.mosi_data} !== {2'b01, 8'h5A}) begin
      bad++; $display("[TB] FAIL rd_cmd got=%b/%h exp=01/5a", {bus.spi_wr_cmd, bus.spi_rd_cmd}, bus.mosi_data);
    end
    waitResp(2, cyc, rv, rdat, re, badNcs);
    total++;
    if (rv !== 4'b0100 || rdat !== 8'hC5 || re !== 1'b0) begin
      bad++; $display("[TB] FAIL rd_rsp got=%b/%h/%b exp=0100/c5/0", rv, rdat, re);
    end
    total++;
    if (badNcs !== 0) begin
      bad++; $display("[TB] FAIL rd_ncs got=%0d exp=0 bad cycles", badNcs);
    end
  endtask

  task automatic test_contention;
    int cyc, badNcs, expIdx;
    logic [3:0] rdy, rv, expOh;
    logic [7:0] rdat, expWord;
    logic re;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_rd = 4'h0;
    bus.req_data = 32'h1312_1110;
    for (int t = 0; t < 8; t++) begin
      expIdx = t % 4;
      expOh = 4'b0001 << expIdx;
      expWord = 8'h10 + 8'(expIdx);
      waitReady(cyc, rdy);
      total++;
      if (rdy !== expOh) begin
        bad++; $display("[TB] FAIL cont_grant%0d got=%b exp=%b", t, rdy, expOh);
      end
      @(negedge clk);
      total++;
      if (bus.mosi_data !== expWord) begin
        bad++; $display("[TB] FAIL cont_mosi%0d got=%h exp=%h", t, bus.mosi_data, expWord);
      end
      waitResp(expIdx, cyc, rv, rdat, re, badNcs);
      total++;
      if (rv !== expOh || badNcs !== 0) begin
        bad++; $display("[TB] FAIL cont_rsp%0d got=%b ncsbad=%0d exp=%b ncsbad=0", t, rv, badNcs, expOh);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_timeout;
    int cyc, badNcs;
    logic [3:0] rdy, rv;
    logic [7:0] rdat;
    logic re;
    modelDead = 1'b1;
    bus.req_valid = 4'b1000;
    bus.req_data = 32'h4400_0000;
    waitReady(cyc, rdy);
    total++;
    if (rdy !== 4'b1000) begin
      bad++; $display("[TB] FAIL to_ready got=%b exp=1000", rdy);
    end
    bus.req_valid = '0;
    waitResp(3, cyc, rv, rdat, re, badNcs);
    total++;
    if (rv !== 4'b1000 || re !== 1'b1) begin
      bad++; $display("[TB] FAIL to_rsp got=%b/%b exp=1000/1", rv, re);
    end
    total++;
    if (cyc !== 66) begin
      bad++; $display("[TB] FAIL to_latency got=%0d exp=66", cyc);
    end
    modelDead = 1'b0;
    bus.req_valid = 4'b0010;
    waitReady(cyc, rdy);
    bus.req_valid = '0;
    waitResp(1, cyc, rv, rdat, re, badNcs);
    total++;
    if (rv !== 4'b0010 || re !== 1'b0) begin
      bad++; $display("[TB] FAIL to_next got=%b/%b exp=0010/0", rv, re);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, badNcs, seen;
    logic [3:0] rdy, rv;
    logic [7:0] rdat;
    logic re;
    modelLen = 20;
    bus.req_valid = 4'b0100;
    bus.req_rd = 4'b0000;
    bus.req_data = 32'h0077_0000;
    waitReady(cyc, rdy);
    bus.req_valid = '0;
    cyc = 0;
    while (cyc < 50 && bus.spi_busy !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    total++;
    if ({bus.arb_busy, bus.ncs_out} !== 5'b1_1011) begin
      bad++; $display("[TB] FAIL mid_inflight got=%b exp=11011", {bus.arb_busy, bus.ncs_out});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.arb_busy, bus.spi_wr_cmd, bus.spi_rd_cmd, bus.rsp_valid} !== 7'b0) begin
      bad++; $display("[TB] FAIL mid_abort got=%b exp=0000000",
                      {bus.arb_busy, bus.spi_wr_cmd, bus.spi_rd_cmd, bus.rsp_valid});
    end
    total++;
    if (bus.ncs_out !== 4'hF) begin
      bad++; $display("[TB] FAIL mid_ncs got=%b exp=1111", bus.ncs_out);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("[TB] FAIL mid_no_rsp got=%0d exp=0", seen);
    end
    bus.req_valid = 4'b1001;
    waitReady(cyc, rdy);
    total++;
    if (rdy !== 4'b0001) begin
      bad++; $display("[TB] FAIL mid_ptr got=%b exp=0001", rdy);
    end
    bus.req_valid = '0;
    waitResp(0, cyc, rv, rdat, re, badNcs);
  endtask

  task automatic test_back_to_back;
    int cyc, badNcs;
    logic [3:0] rdy, rv;
    logic [7:0] rdat, word;
    logic re;
    modelLen = 8;
    word = 8'h31;
    bus.req_valid = 4'b0010;
    bus.req_rd = 4'b0000;
    bus.req_data = {16'h0000, word, 8'h00};
    for (int t = 0; t < 3; t++) begin
      waitReady(cyc, rdy);
      total++;
      if (rdy !== 4'b0010) begin
        bad++; $display("[TB] FAIL b2b_ready%0d got=%b exp=0010", t, rdy);
      end
      if (t > 0) begin
        total++;
        if (cyc !== 2) begin
          bad++; $display("[TB] FAIL b2b_gap%0d got=%0d exp=2", t, cyc);
        end
      end
      bus.req_data = {16'h0000, word + 8'h01, 8'h00};
      @(negedge clk);
      total++;
      if (bus.mosi_data !== word) begin
        bad++; $display("[TB] FAIL b2b_mosi%0d got=%h exp=%h", t, bus.mosi_data, word);
      end
      waitResp(1, cyc, rv, rdat, re, badNcs);
      total++;
      if (rv !== 4'b0010) begin
        bad++; $display("[TB] FAIL b2b_rsp%0d got=%b exp=0010", t, rv);
      end
      word = word + 8'h01;
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting spi_master_arbiter bench");
    test_reset;
    test_single_write;
    test_read;
    test_contention;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin arbiter and sequencer that shares one spi_master instance between N_REQ independent requesters on the same clk domain. It accepts one word transaction (write or read) at a time and issues a one-cycle command pulse to the spi_master. It tracks spi_busy to completion, captures miso_data, returns a per-requester response, and demuxes the master's single ncs_pin to one chip-select line per requester (one slave device per requester).

Parameters:
N_REQ, 4, number of requesters / slave chip-selects (1..16)
MOSI_DATA_WIDTH, 8, write word width; must match spi_master
MISO_DATA_WIDTH, 8, read word width; must match spi_master
START_TIMEOUT, 64, max clk cycles from command pulse to spi_busy rising before the transaction is aborted (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request, level, held until req_ready
req_rd  in  N_REQ  per-requester type: 1=read (spi_rd_cmd), 0=write (spi_wr_cmd)
req_data  in  N_REQ*MOSI_DATA_WIDTH  packed write words, requester i at [i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH]
req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
rsp_valid  out  N_REQ  one-cycle completion pulse to the owning requester
rsp_data  out  MISO_DATA_WIDTH  captured read word, valid with rsp_valid
rsp_err  out  1  start timeout flag, valid with rsp_valid
arb_busy  out  1  high whenever state != IDLE
spi_wr_cmd  out  1  to spi_master
spi_rd_cmd  out  1  to spi_master
mosi_data  out  MOSI_DATA_WIDTH  to spi_master, held stable for the whole transaction
spi_busy  in  1  from spi_master
miso_data  in  MISO_DATA_WIDTH  from spi_master
ncs_pin  in  1  from spi_master ncs_pin
ncs_out  out  N_REQ  per-slave chip-selects, active low

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; rr_ptr = 0.
  - req_ready, rsp_valid, spi_wr_cmd, spi_rd_cmd, rsp_err, arb_busy all 0; mosi_data and rsp_data 0.
  - ncs_out all 1.
- All outputs are registered except ncs_out.
- State machine: IDLE -> GRANT -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, select the first set bit searching cyclically from rr_ptr.
  - Latch idx, req_rd[idx], req_data[idx]; mosi_data <= latched word; go to GRANT.
  - No request: stay in IDLE.
- GRANT:
  - req_ready[idx]=1 for exactly this cycle.
  - rr_ptr <= (idx+1) mod N_REQ.
  - Go to ISSUE.
- ISSUE:
  - spi_rd_cmd=1 if latched rd, else spi_wr_cmd=1, for exactly one cycle.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - spi_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter; when it reaches START_TIMEOUT, set err and go to RESP.
- WAIT_DONE:
  - On the first cycle spi_busy=0, capture miso_data into rsp_data (writes capture too; the value is don't-care) and go to RESP.
  - No timeout in this state.
- RESP:
  - rsp_valid[idx]=1 and rsp_err=err for one cycle; clear err; go to IDLE.
- Latency: req_valid high in IDLE at cycle T gives req_ready at T+1 and cmd pulse at T+2. The earliest next grant after RESP is 2 cycles later.
- ncs_out:
  - Combinational. ncs_out[idx] = ncs_pin while state is in {ISSUE, WAIT_BUSY, WAIT_DONE, RESP}.
  - All other bits, and all bits in IDLE/GRANT, are 1.
  - At most one bit is ever low.
- Fairness:
  - A requester holding req_valid continuously is granted at most once per N_REQ grants while others are requesting.
  - A requester granted in RESP may re-request immediately but loses priority to any other pending requester.
- req_valid dropped before req_ready: the request is ignored if it is not set in IDLE. If it drops during GRANT, the latched transaction still executes.
- req_data/req_rd changes after the IDLE latch have no effect.
- spi_busy already high in IDLE: no command is issued until it falls. IDLE requires spi_busy=0 to grant.
- Reset mid-transaction:
  - Abort to IDLE the next cycle; no rsp_valid is generated.
  - ncs_out goes to all 1 combinationally once the state is IDLE.
- N_REQ=1: rr_ptr stays at 0; the pointer width is at least 1 bit.

Test Plan:
- Single write: req0 valid, rd=0, data 0xA3; spi_master model busy 16 cycles -> req_ready[0] 1 cycle after, spi_wr_cmd 2 cycles after, ncs_out=4'b1110 only while ncs_pin low, rsp_valid[0]=1 with rsp_err=0.
- Read capture: req2 rd=1, model returns miso 0xC5 -> spi_rd_cmd pulse, rsp_valid[2]=1, rsp_data=0xC5, ncs_out[2] is the only low bit.
- Contention: all 4 req_valid held high, 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two ncs_out bits low; req_ready strictly one-hot.
- Timeout: model never asserts spi_busy -> rsp_valid after START_TIMEOUT(64) cycles in WAIT_BUSY with rsp_err=1; next request completes with rsp_err=0.
- Reset mid-op: rst pulse during WAIT_DONE -> next cycle arb_busy=0, cmds 0, ncs_out all 1, no rsp_valid; subsequent request is granted to requester 0 (rr_ptr reset).
- Back-to-back same requester: req1 only, continuously valid -> consecutive grants to 1, two cycles from RESP to next req_ready, mosi_data updated to new word each time.
